b14_mem_arbiter: RTL and testbench

//  Shares one synchronous RAM port (the b14 program/data memory) between two requesters:
//   r0 = b14 core bus adapter, r1 = loader/debug port (preloads opcodes, reads results).

---
 rtl/b14_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_b14_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/b14_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port between the b14 core (r0)
// and the loader/debug port (r1); one transaction in flight, programmable read latency.
module b14_mem_arbiter #(
    parameter int unsigned AW     = 20,
    parameter int unsigned DW     = 31,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t     state;
    logic       grant;
    logic       last;
    logic       lat_we;
    logic [1:0] cnt;
    logic       pick;

    // Contested request goes to the port that did not win last time.
    always_comb begin
        pick = 1'b0;
        if (r0_req && r1_req) begin
            pick = ~last;
        end else if (r1_req) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            grant     <= 1'b0;
            last      <= 1'b1;
            lat_we    <= 1'b0;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r0_ack    <= 1'b0;
            r1_ack    <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
            busy      <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            r0_ack <= 1'b0;
            r1_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (r0_req || r1_req) begin
                        grant     <= pick;
                        last      <= pick;
                        lat_we    <= pick ? r1_we : r0_we;
                        mem_en    <= 1'b1;
                        mem_we    <= pick ? r1_we : r0_we;
                        mem_addr  <= pick ? r1_addr : r0_addr;
                        mem_wdata <= pick ? r1_wdata : r0_wdata;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (lat_we) begin
                        r0_ack <= ~grant;
                        r1_ack <= grant;
                        state  <= S_RESP;
                    end else begin
                        cnt   <= 2'(RD_LAT - 1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Capture lands in the last wait cycle so rdata is valid alongside ack.
                    if (cnt == 2'd0) begin
                        if (grant) begin
                            r1_rdata <= mem_rdata;
                            r1_ack   <= 1'b1;
                        end else begin
                            r0_rdata <= mem_rdata;
                            r0_ack   <= 1'b1;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b14_mem_arbiter.sv
// Directed bench for b14_mem_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// each backed by a small latency-accurate RAM model.
module tb_b14_mem_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req   [2][2];
    logic          we    [2][2];
    logic [AW-1:0] addr  [2][2];
    logic [DW-1:0] wdata [2][2];
    logic          ack   [2][2];
    logic [DW-1:0] rdata [2][2];
    logic          men   [2];
    logic          mwe   [2];
    logic [AW-1:0] maddr [2];
    logic [DW-1:0] mwdata[2];
    logic [DW-1:0] mrdata[2];
    logic          busy  [2];

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_rd [2][2];
    int unsigned lat_of [2] = '{1, 3};

    b14_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
        .clock(clk), .reset(rst_n),
        .r0_req(req[0][0]), .r0_we(we[0][0]), .r0_addr(addr[0][0]), .r0_wdata(wdata[0][0]),
        .r0_ack(ack[0][0]), .r0_rdata(rdata[0][0]),
        .r1_req(req[0][1]), .r1_we(we[0][1]), .r1_addr(addr[0][1]), .r1_wdata(wdata[0][1]),
        .r1_ack(ack[0][1]), .r1_rdata(rdata[0][1]),
        .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
        .mem_rdata(mrdata[0]), .busy(busy[0])
    );

    b14_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
        .clock(clk), .reset(rst_n),
        .r0_req(req[1][0]), .r0_we(we[1][0]), .r0_addr(addr[1][0]), .r0_wdata(wdata[1][0]),
        .r0_ack(ack[1][0]), .r0_rdata(rdata[1][0]),
        .r1_req(req[1][1]), .r1_we(we[1][1]), .r1_addr(addr[1][1]), .r1_wdata(wdata[1][1]),
        .r1_ack(ack[1][1]), .r1_rdata(rdata[1][1]),
        .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
        .mem_rdata(mrdata[1]), .busy(busy[1])
    );

    // RAM models: data visible exactly LAT cycles after the mem_en cycle, junk otherwise.
    for (genvar g = 0; g < 2; g++) begin : g_ram
        localparam int unsigned LAT = (g == 0) ? 1 : 3;
        logic [DW-1:0] ram  [256];
        logic [DW-1:0] pipe [4];
        logic          pv   [4];
        always @(posedge clk) begin
            if (men[g] && mwe[g]) ram[maddr[g][7:0]] <= mwdata[g];
            pipe[0] <= ram[maddr[g][7:0]];
            pv[0]   <= men[g] && !mwe[g];
            for (int k = 1; k < 4; k++) begin
                pipe[k] <= pipe[k-1];
                pv[k]   <= pv[k-1];
            end
        end
        assign mrdata[g] = pv[LAT-1] ? pipe[LAT-1] : 31'h2A5A5A5A;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic prev_en [2] = '{1'b0, 1'b0};
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (men[d]) check("mem_en_gap", 64'(prev_en[d]), 64'd0);
            prev_en[d] = men[d];
        end
    end

    task automatic do_txn(input int unsigned d, input int unsigned p, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] erd);
        int en_cyc = -1;
        int ack_cyc = -1;
        int en_n = 0;
        logic oth = 1'b0;
        logic en_we = 1'b0;
        logic [AW-1:0] en_a = '0;
        logic [DW-1:0] en_wd = '0;
        logic [DW-1:0] rd_at_ack = '0;
        req[d][p] = 1'b1; we[d][p] = w; addr[d][p] = a; wdata[d][p] = wd;
        for (int c = 1; c <= 12; c++) begin
            tick();
            // Inputs wander after the latch; the latched copy must be used.
            if (c == 1) begin
                we[d][p] = ~w; addr[d][p] = ~a; wdata[d][p] = ~wd;
            end
            if (men[d]) begin
                en_n++;
                if (en_cyc < 0) begin
                    en_cyc = c; en_we = mwe[d]; en_a = maddr[d]; en_wd = mwdata[d];
                end
            end
            if (ack[d][p]) begin
                if (ack_cyc < 0) begin
                    ack_cyc = c; rd_at_ack = rdata[d][p];
                end
                req[d][p] = 1'b0;
            end
            if (ack[d][1-p]) oth = 1'b1;
        end
        req[d][p] = 1'b0;
        if (!w) exp_rd[d][p] = erd;
        check("en_cycle", 64'(en_cyc), 64'd1);
        check("en_count", 64'(en_n), 64'd1);
        check("mem_we", 64'(en_we), 64'(w));
        check("mem_addr", 64'(en_a), 64'(a));
        check("mem_wdata", 64'(en_wd), 64'(wd));
        check("ack_cycle", 64'(ack_cyc), w ? 64'd2 : 64'(lat_of[d] + 2));
        check("other_ack", 64'(oth), 64'd0);
        check("rdata_at_ack", 64'(rd_at_ack), 64'(exp_rd[d][p]));
        check("rdata_held", 64'(rdata[d][p]), 64'(exp_rd[d][p]));
        check("other_rdata", 64'(rdata[d][1-p]), 64'(exp_rd[d][1-p]));
        check("busy_after", 64'(busy[d]), 64'd0);
    endtask

    typedef struct {
        int unsigned   d;
        int unsigned   p;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] erd;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int first_c, second_c, r0_c, r1_c, en_n, nack;
        logic [AW-1:0] first_a, second_a;
        int ack_port [4];
        int ack_c [4];
        logic [DW-1:0] ack_dat [4];
        logic dual;

        tbl[0] = '{0, 0, 1'b1, 20'h00010, 31'h1234567,  31'h0};
        tbl[1] = '{0, 0, 1'b1, 20'hFFFFF, 31'h7FFFFFFF, 31'h0};
        tbl[2] = '{0, 1, 1'b0, 20'hFFFFF, 31'h0,        31'h7FFFFFFF};
        tbl[3] = '{0, 1, 1'b1, 20'h00000, 31'h0000AAA,  31'h0};
        tbl[4] = '{0, 0, 1'b0, 20'h00010, 31'h0,        31'h1234567};
        tbl[5] = '{0, 0, 1'b1, 20'h00001, 31'h2AAAAAAA, 31'h0};
        tbl[6] = '{1, 0, 1'b1, 20'h00005, 31'h3C3C3C3,  31'h0};
        tbl[7] = '{1, 0, 1'b0, 20'h00005, 31'h0,        31'h3C3C3C3};
        tbl[8] = '{1, 1, 1'b0, 20'h00005, 31'h0,        31'h3C3C3C3};
        tbl[9] = '{0, 1, 1'b0, 20'h00010, 31'h0,        31'h1234567};

        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                req[d][p] = 1'b0; we[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0;
                exp_rd[d][p] = '0;
            end
        end

        // Reset held with both ports requesting; r0 must win first after release.
        req[0][0] = 1'b1; we[0][0] = 1'b1; addr[0][0] = 20'h00020; wdata[0][0] = 31'h55;
        req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 20'h00030; wdata[0][1] = 31'h66;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_mem_en", 64'(men[0]), 64'd0);
            check("rst_acks", 64'({ack[0][0], ack[0][1]}), 64'd0);
            check("rst_busy", 64'(busy[0]), 64'd0);
        end
        check("rst_rdata", 64'({rdata[0][0], rdata[0][1]}), 64'd0);
        check("rst_mem_addr", 64'(maddr[0]), 64'd0);
        rst_n = 1'b1;
        first_c = -1; second_c = -1; r0_c = -1; r1_c = -1; en_n = 0;
        first_a = '0; second_a = '0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (men[0]) begin
                en_n++;
                if (first_c < 0) begin first_c = c; first_a = maddr[0]; end
                else if (second_c < 0) begin second_c = c; second_a = maddr[0]; end
            end
            if (ack[0][0]) begin if (r0_c < 0) r0_c = c; req[0][0] = 1'b0; end
            if (ack[0][1]) begin if (r1_c < 0) r1_c = c; req[0][1] = 1'b0; end
        end
        req[0][0] = 1'b0; req[0][1] = 1'b0;
        check("rr_first_cycle", 64'(first_c), 64'd1);
        check("rr_first_addr", 64'(first_a), 64'h20);
        check("rr_r0_ack", 64'(r0_c), 64'd2);
        check("rr_second_cycle", 64'(second_c), 64'd4);
        check("rr_second_addr", 64'(second_a), 64'h30);
        check("rr_r1_ack", 64'(r1_c), 64'd5);
        check("rr_en_count", 64'(en_n), 64'd2);

        for (int i = 0; i < 10; i++) begin
            do_txn(tbl[i].d, tbl[i].p, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].erd);
        end

        // Continuous contention: grants alternate starting with r0 (r1 won last).
        req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 20'h00000;
        req[0][1] = 1'b1; we[0][1] = 1'b0; addr[0][1] = 20'h00001;
        nack = 0; dual = 1'b0;
        for (int i = 0; i < 4; i++) begin ack_port[i] = -1; ack_c[i] = -1; ack_dat[i] = '0; end
        for (int c = 1; c <= 30 && nack < 4; c++) begin
            tick();
            if (ack[0][0] && ack[0][1]) dual = 1'b1;
            if (ack[0][0] || ack[0][1]) begin
                ack_port[nack] = ack[0][1] ? 1 : 0;
                ack_c[nack] = c;
                ack_dat[nack] = ack[0][1] ? rdata[0][1] : rdata[0][0];
                nack++;
            end
        end
        req[0][0] = 1'b0; req[0][1] = 1'b0;
        check("alt_ack_count", 64'(nack), 64'd4);
        check("alt_dual_ack", 64'(dual), 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("alt_port", 64'(ack_port[i]), 64'(i % 2));
            check("alt_cycle", 64'(ack_c[i]), 64'(3 + 4 * i));
            check("alt_data", 64'(ack_dat[i]), (i % 2 == 1) ? 64'h2AAAAAAA : 64'hAAA);
        end
        exp_rd[0][0] = 31'h0000AAA; exp_rd[0][1] = 31'h2AAAAAAA;
        tick(); tick();
        check("alt_idle_busy", 64'(busy[0]), 64'd0);

        // Reset during WAIT aborts the read: no ack, busy drops, rdata back to reset.
        req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 20'h00010;
        tick();
        check("abort_en", 64'(men[0]), 64'd1);
        tick();
        check("abort_in_wait", 64'(busy[0]), 64'd1);
        rst_n = 1'b0; req[0][0] = 1'b0;
        tick();
        check("abort_busy", 64'(busy[0]), 64'd0);
        check("abort_ack", 64'({ack[0][0], ack[0][1]}), 64'd0);
        check("abort_rdata", 64'({rdata[0][0], rdata[0][1]}), 64'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("abort_no_late_ack", 64'({ack[0][0], ack[0][1], men[0]}), 64'd0);
        end
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) exp_rd[d][p] = '0;
        end
        do_txn(0, 1, 1'b1, 20'h00040, 31'h0BADF00D, 31'h0);
        do_txn(0, 0, 1'b0, 20'h00040, 31'h0, 31'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
